// File: rtl/decode_pipe.sv
// decode_pipe: y86 decode stage, from fetch output to execute input.
//
// Contents: the D pipeline register, a 15-entry register file, the operand
// forwarding network, load-use / ret / mispredict hazard detection with the
// stall and bubble control it implies, and the E pipeline register.
//
// Parameters
//   DATA_W  width of register values, valC and valP
//   FWD_EN  1 = full forwarding; 0 = no forwarding, stall on any pending RAW
//
// Ports
//   clock, reset_n                  rising-edge clock, async active-low reset
//   f_stat/f_icode/f_ifun/f_rA/f_rB fetch outputs (4 bits each)
//   f_valC, f_valP                  fetch outputs (DATA_W)
//   e_dstE, e_valE, e_Cnd           execute-stage result and condition
//   M_icode, M_dstE, M_dstM, M_valE memory-stage register fields
//   m_dstM, m_valM                  memory-stage load result
//   W_dstE, W_dstM, W_valE, W_valM  writeback ports (also forwarded)
//   F_stall                         hold PC/fetch (combinational)
//   E_*                             registered E pipeline register fields
module decode_pipe #(
    parameter int DATA_W = 64,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        f_stat,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [DATA_W-1:0] f_valC,
    input  logic [DATA_W-1:0] f_valP,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic              e_Cnd,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        m_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    output logic              F_stall,
    output logic [3:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB
);

    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] R_RSP    = 4'h4;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // D pipeline register
    logic [3:0]        d_stat_reg, d_icode_reg, d_ifun_reg, d_ra_reg, d_rb_reg;
    logic [DATA_W-1:0] d_valc_reg, d_valp_reg;

    // Decoded register IDs and operand values
    logic [3:0]        d_dst_e, d_dst_m, d_src_a, d_src_b;
    logic [DATA_W-1:0] rf_a, rf_b, d_val_a, d_val_b;

    // Hazard and control
    logic load_use_fwd, raw, load_use, mispredict, ret_p;
    logic d_stall, d_bubble, e_bubble;

    // ------------------------------------------------------------------
    // Register file: one register per entry so each has its own write
    // decode. W_dstM is tested first so it wins when both ports target
    // the same register (popq %rsp).
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [0:14];

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : gen_rf
            localparam logic [3:0] IDX = 4'(gi);
            logic [DATA_W-1:0] value_reg;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    value_reg <= '0;
                else if (W_dstM == IDX)
                    value_reg <= W_valM;
                else if (W_dstE == IDX)
                    value_reg <= W_valE;
            end
            assign rf_q[gi] = value_reg;
        end
    endgenerate

    // ID 0xF has no storage; reading it yields 0.
    assign rf_a = (d_src_a == R_NONE) ? '0 : rf_q[d_src_a];
    assign rf_b = (d_src_b == R_NONE) ? '0 : rf_q[d_src_b];

    // ------------------------------------------------------------------
    // Register-ID decode
    // ------------------------------------------------------------------
    always_comb begin
        d_dst_e = R_NONE;
        d_dst_m = R_NONE;
        d_src_a = R_NONE;
        d_src_b = R_NONE;
        case (d_icode_reg)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:         d_dst_e = d_rb_reg;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_dst_e = R_RSP;
            default:                           d_dst_e = R_NONE;
        endcase
        case (d_icode_reg)
            I_MRMOVQ, I_POPQ:                  d_dst_m = d_ra_reg;
            default:                           d_dst_m = R_NONE;
        endcase
        case (d_icode_reg)
            I_RRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ:                    d_src_a = d_ra_reg;
            I_RET, I_POPQ:                     d_src_a = R_RSP;
            default:                           d_src_a = R_NONE;
        endcase
        case (d_icode_reg)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:         d_src_b = d_rb_reg;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_src_b = R_RSP;
            default:                           d_src_b = R_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Forwarding: youngest producer first. 0xF never matches.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] fwd_value(input logic [3:0] src,
                                                    input logic [DATA_W-1:0] file_val);
        if (src == R_NONE)      return file_val;
        else if (src == e_dstE) return e_valE;
        else if (src == m_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return file_val;
    endfunction

    always_comb begin
        // jXX and call carry the fall-through / return address in valA.
        if (d_icode_reg == I_JXX || d_icode_reg == I_CALL)
            d_val_a = d_valp_reg;
        else if (FWD_EN)
            d_val_a = fwd_value(d_src_a, rf_a);
        else
            d_val_a = rf_a;

        if (FWD_EN)
            d_val_b = fwd_value(d_src_b, rf_b);
        else
            d_val_b = rf_b;
    end

    // ------------------------------------------------------------------
    // Hazards
    // ------------------------------------------------------------------
    // A source is pending while any in-flight instruction will still write it.
    function automatic logic pending(input logic [3:0] src);
        return (src != R_NONE) &&
               (src == E_dstE || src == E_dstM || src == M_dstE ||
                src == M_dstM || src == W_dstE || src == W_dstM);
    endfunction

    assign raw          = pending(d_src_a) || pending(d_src_b);
    assign load_use_fwd = (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
                          (E_dstM != R_NONE) &&
                          (E_dstM == d_src_a || E_dstM == d_src_b);
    assign load_use     = FWD_EN ? load_use_fwd : raw;
    assign mispredict   = (E_icode == I_JXX) && !e_Cnd;
    assign ret_p        = (d_icode_reg == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

    assign F_stall  = load_use | ret_p;
    assign d_stall  = load_use;
    assign d_bubble = mispredict | (ret_p & !load_use);
    assign e_bubble = mispredict | load_use;

    // ------------------------------------------------------------------
    // D register: bubble beats stall so a mispredict always flushes.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || d_bubble) begin
            d_stat_reg  <= S_AOK;
            d_icode_reg <= I_NOP;
            d_ifun_reg  <= 4'h0;
            d_ra_reg    <= R_NONE;
            d_rb_reg    <= R_NONE;
            d_valc_reg  <= '0;
            d_valp_reg  <= '0;
        end else if (!d_stall) begin
            d_stat_reg  <= f_stat;
            d_icode_reg <= f_icode;
            d_ifun_reg  <= f_ifun;
            d_ra_reg    <= f_rA;
            d_rb_reg    <= f_rB;
            d_valc_reg  <= f_valC;
            d_valp_reg  <= f_valP;
        end
    end

    // ------------------------------------------------------------------
    // E register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || e_bubble) begin
            E_stat  <= S_AOK;
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_dstE  <= R_NONE;
            E_dstM  <= R_NONE;
            E_srcA  <= R_NONE;
            E_srcB  <= R_NONE;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
        end else begin
            E_stat  <= d_stat_reg;
            E_icode <= d_icode_reg;
            E_ifun  <= d_ifun_reg;
            E_dstE  <= d_dst_e;
            E_dstM  <= d_dst_m;
            E_srcA  <= d_src_a;
            E_srcB  <= d_src_b;
            E_valC  <= d_valc_reg;
            E_valA  <= d_val_a;
            E_valB  <= d_val_b;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed self-checking bench for decode_pipe.
// Two instances share all inputs: u_fwd (FWD_EN=1) and u_nofwd (FWD_EN=0).
module tb_decode_pipe;

    localparam int DW = 64;
    localparam logic [3:0] RN = 4'hF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;
    logic [3:0]    f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [DW-1:0] f_valC, f_valP;
    logic [3:0]    e_dstE;
    logic [DW-1:0] e_valE;
    logic          e_Cnd;
    logic [3:0]    M_icode, M_dstE, M_dstM, m_dstM;
    logic [DW-1:0] M_valE, m_valM;
    logic [3:0]    W_dstE, W_dstM;
    logic [DW-1:0] W_valE, W_valM;

    logic          F_stall, n_F_stall;
    logic [3:0]    E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [3:0]    n_E_stat, n_E_icode, n_E_ifun, n_E_dstE, n_E_dstM, n_E_srcA, n_E_srcB;
    logic [DW-1:0] E_valC, E_valA, E_valB, n_E_valC, n_E_valA, n_E_valB;

    decode_pipe #(.DATA_W(DW), .FWD_EN(1'b1)) u_fwd (
        .clock(clock), .reset_n(reset_n),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .e_dstE(e_dstE), .e_valE(e_valE), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
        .m_dstM(m_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .F_stall(F_stall),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
    );

    decode_pipe #(.DATA_W(DW), .FWD_EN(1'b0)) u_nofwd (
        .clock(clock), .reset_n(reset_n),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .e_dstE(e_dstE), .e_valE(e_valE), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
        .m_dstM(m_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .F_stall(n_F_stall),
        .E_stat(n_E_stat), .E_icode(n_E_icode), .E_ifun(n_E_ifun), .E_dstE(n_E_dstE),
        .E_dstM(n_E_dstM), .E_srcA(n_E_srcA), .E_srcB(n_E_srcB),
        .E_valC(n_E_valC), .E_valA(n_E_valA), .E_valB(n_E_valB)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end else begin
            $display("check %s: 0x%0h ok", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [DW-1:0] valc, input logic [DW-1:0] valp);
        f_stat  = 4'h1;
        f_icode = icode;
        f_ifun  = ifun;
        f_rA    = ra;
        f_rB    = rb;
        f_valC  = valc;
        f_valP  = valp;
    endtask

    task automatic idle();
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        e_dstE = RN; e_valE = '0; e_Cnd = 1'b1;
        M_icode = 4'h1; M_dstE = RN; M_dstM = RN; M_valE = '0;
        m_dstM = RN; m_valM = '0;
        W_dstE = RN; W_dstM = RN; W_valE = '0; W_valM = '0;
    endtask

    // Streams rrmovq rA=i for every register and checks the value that
    // reaches E_valA two edges later (base 0 means all registers are zero).
    task automatic read_regs(input logic [DW-1:0] base);
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) fetch(4'h2, 4'h0, 4'(i), RN, '0, '0);
            else        fetch(4'h1, 4'h0, RN, RN, '0, '0);
            tick();
            if (i >= 1)
                check($sformatf("rf_read_r%0d", i - 1), E_valA,
                      (base == '0) ? '0 : base + DW'(i - 1));
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        reset_n = 1'b0;
        idle();
        tick(); tick();
        check("rst_E_icode", E_icode, 4'h1);
        check("rst_E_stat",  E_stat,  4'h1);
        check("rst_E_dstE",  E_dstE,  RN);
        check("rst_E_srcA",  E_srcA,  RN);
        check("rst_E_valA",  E_valA,  '0);
        reset_n = 1'b1;
        #1;
        check("rst_F_stall", F_stall, 1'b0);
        tick();

        // ---------------- register file write/read ----------------
        for (int i = 0; i < 15; i++) begin
            W_dstE = 4'(i);
            W_valE = 64'h100 + DW'(i);
            tick();
        end
        W_dstE = RN; W_valE = '0;
        read_regs(64'h100);

        // async reset clears file and pipeline without a clock edge
        reset_n = 1'b0;
        #1;
        check("async_rst_E_icode", E_icode, 4'h1);
        tick();
        reset_n = 1'b1;
        tick();
        read_regs('0);

        // ---------------- forwarding priority ----------------
        fetch(4'h2, 4'h0, 4'h3, RN, '0, '0);
        tick();
        e_dstE = 4'h3; e_valE = 64'hAA; M_dstE = 4'h3; M_valE = 64'hBB;
        tick();
        check("fwd_e_over_M", E_valA, 64'hAA);
        e_dstE = RN; m_dstM = 4'h3; m_valM = 64'h77;
        tick();
        check("fwd_m_over_M", E_valA, 64'h77);
        m_dstM = RN; W_dstE = 4'h3; W_valE = 64'hCC; W_dstM = 4'h3; W_valM = 64'hDD;
        tick();
        check("fwd_M_over_W", E_valA, 64'hBB);
        M_dstE = RN;
        tick();
        check("fwd_WM_over_WE", E_valA, 64'hDD);
        W_dstE = RN; W_dstM = RN;
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        tick();
        check("file_after_W", E_valA, 64'hDD);

        // valB chain: addq %rbp,%rsi with only W_dstE matching srcB
        fetch(4'h6, 4'h0, 4'h5, 4'h6, '0, '0);
        tick();
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        W_dstE = 4'h6; W_valE = 64'h66;
        tick();
        W_dstE = RN;
        check("opq_valB_fwd", E_valB, 64'h66);
        check("opq_valA_file", E_valA, '0);
        check("opq_dstE", E_dstE, 4'h6);

        // call: valA = valP, valB = forwarded %rsp, dstE = %rsp
        fetch(4'h8, 4'h0, RN, RN, 64'h400, 64'h123);
        tick();
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        e_dstE = 4'h4; e_valE = 64'h5A;
        tick();
        e_dstE = RN;
        check("call_valA", E_valA, 64'h123);
        check("call_valB", E_valB, 64'h5A);
        check("call_dstE", E_dstE, 4'h4);
        check("call_valC", E_valC, 64'h400);
        check("call_srcA", E_srcA, RN);

        // ---------------- load-use ----------------
        fetch(4'h5, 4'h0, 4'h2, RN, 64'h20, '0);     // mrmovq -> %rdx
        tick();
        fetch(4'h6, 4'h0, 4'h2, 4'h3, '0, '0);       // addq %rdx,%rbx
        tick();
        fetch(4'h3, 4'h0, RN, 4'h5, 64'h55, '0);     // irmovq 0x55,%rbp
        #1;
        check("lu_F_stall", F_stall, 1'b1);
        tick();
        check("lu_E_bubble", E_icode, 4'h1);
        M_icode = 4'h5; M_dstM = 4'h2; m_dstM = 4'h2; m_valM = 64'h99;
        #1;
        check("lu_stall_one_cycle", F_stall, 1'b0);
        tick();
        check("lu_addq_in_E", E_icode, 4'h6);
        check("lu_valA_m_fwd", E_valA, 64'h99);
        check("lu_srcA", E_srcA, 4'h2);
        M_icode = 4'h1; M_dstM = RN; m_dstM = RN; m_valM = '0;
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        tick();
        check("lu_next_icode", E_icode, 4'h3);
        check("lu_next_valC", E_valC, 64'h55);

        // reset during a load-use stall
        fetch(4'h5, 4'h0, 4'h2, RN, '0, '0);
        tick();
        fetch(4'h6, 4'h0, 4'h2, 4'h3, '0, '0);
        tick();
        #1;
        check("rst_stall_before", F_stall, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_stall_cleared", F_stall, 1'b0);
        tick();
        reset_n = 1'b1;
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        tick();

        // ---------------- mispredict ----------------
        fetch(4'h7, 4'h1, RN, RN, 64'h300, 64'h200);
        tick();
        fetch(4'h3, 4'h0, RN, 4'h1, 64'h11, '0);
        tick();
        check("mp_jxx_in_E", E_icode, 4'h7);
        check("mp_jxx_valA", E_valA, 64'h200);
        e_Cnd = 1'b0;
        fetch(4'h3, 4'h0, RN, 4'h2, 64'h22, '0);
        #1;
        check("mp_no_stall", F_stall, 1'b0);
        tick();
        e_Cnd = 1'b1;
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        check("mp_E_bubble", E_icode, 4'h1);
        tick();
        check("mp_D_bubble", E_icode, 4'h1);
        check("mp_D_bubble_dstE", E_dstE, RN);

        // ---------------- ret ----------------
        fetch(4'h9, 4'h0, RN, RN, '0, 64'h500);
        tick();
        fetch(4'h3, 4'h0, RN, 4'h1, 64'h33, '0);
        #1;
        check("ret_stall_c1", F_stall, 1'b1);
        tick();
        check("ret_in_E", E_icode, 4'h9);
        check("ret_srcA", E_srcA, 4'h4);
        check("ret_stall_c2", F_stall, 1'b1);
        tick();
        M_icode = 4'h9;
        #1;
        check("ret_stall_c3", F_stall, 1'b1);
        check("ret_bubble_c3", E_icode, 4'h1);
        tick();
        M_icode = 4'h1;
        #1;
        check("ret_stall_c4", F_stall, 1'b0);
        check("ret_bubble_c4", E_icode, 4'h1);
        tick();
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        tick();
        check("ret_resume", E_icode, 4'h3);

        // ---------------- FWD_EN = 0 ----------------
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        fetch(4'h3, 4'h0, RN, 4'h0, 64'h5, '0);     // irmovq 5,%rax
        tick();
        fetch(4'h6, 4'h0, 4'h0, 4'h3, '0, '0);      // addq %rax,%rbx
        tick();
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        #1;
        check("nf_irmovq_E", n_E_icode, 4'h3);
        check("nf_stall_E", n_F_stall, 1'b1);
        tick();
        check("nf_bubble_1", n_E_icode, 4'h1);
        M_icode = 4'h3; M_dstE = 4'h0; M_valE = 64'h5;
        #1;
        check("nf_stall_M", n_F_stall, 1'b1);
        tick();
        check("nf_bubble_2", n_E_icode, 4'h1);
        M_icode = 4'h1; M_dstE = RN; M_valE = '0;
        W_dstE = 4'h0; W_valE = 64'h5;
        #1;
        check("nf_stall_W", n_F_stall, 1'b1);
        tick();
        check("nf_bubble_3", n_E_icode, 4'h1);
        W_dstE = RN; W_valE = '0;
        #1;
        check("nf_stall_done", n_F_stall, 1'b0);
        tick();
        check("nf_addq_E", n_E_icode, 4'h6);
        check("nf_addq_valA", n_E_valA, 64'h5);

        // popq %rsp: both write ports hit %rsp, W_valM lands in the file
        W_dstE = 4'h4; W_valE = 64'h10; W_dstM = 4'h4; W_valM = 64'h20;
        tick();
        W_dstE = RN; W_dstM = RN; W_valE = '0; W_valM = '0;
        fetch(4'h2, 4'h0, 4'h4, RN, '0, '0);
        tick();
        fetch(4'h1, 4'h0, RN, RN, '0, '0);
        tick();
        check("nf_popq_rsp", n_E_valA, 64'h20);
        check("fw_popq_rsp", E_valA, 64'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
